// File: rtl/sipo_deser_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sipo_deser_hs                                                   |
// | Purpose  : Double-buffered serial-in/parallel-out deserialiser with        |
// |            selectable bit order, flush and valid/ready parallel output.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sipo_deser_hs #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [0:0]       c_st_fill  = 1'b0;
    localparam logic [0:0]       c_st_stall = 1'b1;
    localparam logic [CNT_W-1:0] c_last     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_full     = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_sr_next;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_handshake;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_next = {r_sr[WIDTH-2:0], in};
        end else begin : g_lsb_first
            assign w_sr_next = {in, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // rst gating keeps in_ready low for the whole reset window, not just after its first edge
    assign in_ready    = rst & (r_state == c_st_fill);
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_handshake = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_fill;
            r_sr        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else if (flush) begin
            // A pending STALL word is dropped; only a plain handshake can clear out_valid
            r_sr    <= '0;
            r_cnt   <= '0;
            r_state <= c_st_fill;
            if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end else if (r_state == c_st_stall) begin
            if (w_slot_free) begin
                r_out       <= r_sr;
                r_out_valid <= 1'b1;
                r_cnt       <= '0;
                r_state     <= c_st_fill;
            end
        end else if (w_accept) begin
            r_sr <= w_sr_next;
            if (r_cnt == c_last) begin
                if (w_slot_free) begin
                    r_out       <= w_sr_next;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt   <= c_full;
                    r_state <= c_st_stall;
                end
            end else begin
                r_cnt <= r_cnt + c_one;
                if (w_handshake) begin
                    r_out_valid <= 1'b0;
                end
            end
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign bit_cnt   = r_cnt;

endmodule
`default_nettype wire
